// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the 3-bit CRC (poly x^3+1) generator/checker family.
//   CRC_W      : CRC width (3)
//   CRC_POLY   : generator polynomial, x^3 + 1
//   FOLD_MAX_W : widest data word crc_fold() accepts (zero-extend narrower words)
//   crc_state_e: serial checker FSM states
//   crc_fold() : reference parallel CRC. Because x^3 == 1 mod (x^3+1), the
//                remainder of data*x^3 is the XOR-fold of data bits by i mod 3.
// -----------------------------------------------------------------------------
package crc_pkg;

   localparam int         CRC_W      = 3;
   localparam logic [3:0] CRC_POLY   = 4'b1001;
   localparam int         FOLD_MAX_W = 64;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } crc_state_e;

   // Bit j of the result is the XOR of every data[i] with i mod 3 == j.
   function automatic logic [CRC_W-1:0] crc_fold(input logic [FOLD_MAX_W-1:0] data);
      logic [CRC_W-1:0] acc;
      logic [1:0]       j;
      acc = 3'b000;
      for (int i = 0; i < FOLD_MAX_W; i++) begin
         j      = 2'(i % CRC_W);
         acc[j] = acc[j] ^ data[i];
      end
      return acc;
   endfunction

endpackage

// File: rtl/crc_residue_ser.sv
// -----------------------------------------------------------------------------
// crc_residue_ser
// Serial remainder register for division by CRC_POLY, one bit per enabled cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   seed       : load the residue as if this bit were the first of a codeword
//   shift      : fold ser_bit into the running residue
//   clear      : return the residue to zero (highest priority)
//   ser_bit    : incoming codeword bit
//   shift_val  : residue after folding ser_bit in (combinational), used by the
//                parent to judge the final bit without waiting a cycle
// -----------------------------------------------------------------------------
module crc_residue_ser
   import crc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed,
   input  logic             shift,
   input  logic             clear,
   input  logic             ser_bit,
   output logic [CRC_W-1:0] shift_val
);

   logic [CRC_W-1:0] residue_r;
   logic [CRC_W-1:0] fb_s;
   logic [CRC_W-1:0] bit_ext_s;
   logic [CRC_W-1:0] seed_val_s;

   // Next-residue arithmetic: shift left, feed back the MSB through the poly taps.
   always_comb begin
      bit_ext_s  = {{(CRC_W-1){1'b0}}, ser_bit};
      fb_s       = {CRC_W{residue_r[CRC_W-1]}} & CRC_POLY[CRC_W-1:0];
      shift_val  = {residue_r[CRC_W-2:0], 1'b0} ^ fb_s ^ bit_ext_s;
      // A first bit divides into an empty remainder, leaving just that bit.
      seed_val_s = bit_ext_s;
   end

   // Residue register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         residue_r <= {CRC_W{1'b0}};
      end else if (clear) begin
         residue_r <= {CRC_W{1'b0}};
      end else if (seed) begin
         residue_r <= seed_val_s;
      end else if (shift) begin
         residue_r <= shift_val;
      end else begin
         residue_r <= residue_r;
      end
   end

endmodule

// File: rtl/crc_ser_checker.sv
// -----------------------------------------------------------------------------
// crc_ser_checker
// Bit-serial receiver for DATA_W data bits followed by a 3-bit CRC (x^3+1),
// MSB first. Deserializes the data, checks the residue, and holds the result in
// a one-entry valid/ready buffer.
// Parameters:
//   DATA_W : data bits per codeword (>= 1)
//   CNT_W  : statistics counter width (only with CRC_CHK_STATS_EN)
// Ports:
//   ser_valid/ser_bit/ser_sof/ser_ready : serial input, accept = valid & ready
//   out_valid/out_ready                 : result handshake
//   out_data, out_crc_err               : received word, 1 = residue nonzero
//   sync_err                            : one-cycle pulse, codeword aborted by SOF
//   frame_cnt, err_cnt                  : saturating result / CRC-error counts,
//                                         present only when the macro
//                                         CRC_CHK_STATS_EN is defined
// -----------------------------------------------------------------------------
module crc_ser_checker
   import crc_pkg::*;
#(
   parameter int DATA_W = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_valid,
   input  logic              ser_bit,
   input  logic              ser_sof,
   output logic              ser_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_crc_err,
   output logic              sync_err
`ifdef CRC_CHK_STATS_EN
   ,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
      $error("crc_ser_checker: DATA_W and CNT_W must both be at least 1");
   end

   localparam int            CW       = $clog2(DATA_W + 4);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] DATA_CNT = CW'(DATA_W);
   // Count held while waiting for the final CRC bit.
   localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W + 2);

   crc_state_e        state_r, state_next_s;
   logic [CW-1:0]     cnt_r, cnt_next_s;
   logic [DATA_W-1:0] shift_r, shift_next_s, bit_ext_s;
   logic              accept_s, seed_s, res_shift_s, res_clear_s;
   logic              load_s, sync_pulse_s;
   logic [CRC_W-1:0]  residue_shift_s;
   logic              out_valid_r, out_crc_err_r, sync_err_r;
   logic [DATA_W-1:0] out_data_r;

   assign ser_ready   = !out_valid_r | out_ready;
   assign accept_s    = ser_valid & ser_ready;
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign out_crc_err = out_crc_err_r;
   assign sync_err    = sync_err_r;

   crc_residue_ser u_residue (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed      (seed_s),
      .shift     (res_shift_s),
      .clear     (res_clear_s),
      .ser_bit   (ser_bit),
      .shift_val (residue_shift_s)
   );

   // Incoming bit placed in the LSB position of a data-width word.
   always_comb begin
      bit_ext_s    = {DATA_W{1'b0}};
      bit_ext_s[0] = ser_bit;
   end

   // FSM next state, bit counter, data shifter and residue controls.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      shift_next_s = shift_r;
      seed_s       = 1'b0;
      res_shift_s  = 1'b0;
      res_clear_s  = 1'b0;
      load_s       = 1'b0;
      sync_pulse_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && ser_sof) begin
               state_next_s = SHIFT;
               cnt_next_s   = CNT_ONE;
               seed_s       = 1'b1;
               shift_next_s = bit_ext_s;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (accept_s && ser_sof) begin
               // SOF inside a codeword: drop the partial word, restart here.
               sync_pulse_s = 1'b1;
               cnt_next_s   = CNT_ONE;
               seed_s       = 1'b1;
               shift_next_s = bit_ext_s;
            end else if (accept_s) begin
               res_shift_s = 1'b1;
               if (cnt_r < DATA_CNT) begin
                  shift_next_s = (shift_r << 1'b1) | bit_ext_s;
               end else begin
                  shift_next_s = shift_r;
               end
               if (cnt_r == LAST_IDX) begin
                  load_s       = 1'b1;
                  res_clear_s  = 1'b1;
                  cnt_next_s   = {CW{1'b0}};
                  state_next_s = IDLE;
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end else begin
               state_next_s = SHIFT;
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = {CW{1'b0}};
            res_clear_s  = 1'b1;
         end
      endcase
   end

   // FSM state, bit counter and data shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         shift_r <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         shift_r <= shift_next_s;
      end
   end

   // Output buffer: a fresh result takes priority over the consumer's pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r   <= 1'b0;
         out_data_r    <= {DATA_W{1'b0}};
         out_crc_err_r <= 1'b0;
         sync_err_r    <= 1'b0;
      end else begin
         sync_err_r <= sync_pulse_s;
         if (load_s) begin
            out_valid_r   <= 1'b1;
            out_data_r    <= shift_r;
            out_crc_err_r <= |residue_shift_s;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

`ifdef CRC_CHK_STATS_EN
   logic [CNT_W-1:0] frame_cnt_r, err_cnt_r;

   assign frame_cnt = frame_cnt_r;
   assign err_cnt   = err_cnt_r;

   // Saturating result and CRC-error counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_r <= {CNT_W{1'b0}};
         err_cnt_r   <= {CNT_W{1'b0}};
      end else if (load_s) begin
         if (frame_cnt_r != {CNT_W{1'b1}}) begin
            frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
         if ((|residue_shift_s) && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            err_cnt_r <= err_cnt_r;
         end
      end else begin
         frame_cnt_r <= frame_cnt_r;
         err_cnt_r   <= err_cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_crc_ser_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_ser_checker
// Directed and random stimulus for crc_ser_checker (DATA_W = 7). Inputs change
// 1 ns after a rising edge; outputs are sampled on the falling edge or 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_crc_ser_checker;
   import crc_pkg::*;

   localparam int DATA_W = 7;
   localparam int CNT_W  = 16;
   localparam int N_RAND = 1000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              ser_valid = 1'b0;
   logic              ser_bit = 1'b0;
   logic              ser_sof = 1'b0;
   logic              out_ready = 1'b1;
   logic              ser_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_crc_err;
   logic              sync_err;
`ifdef CRC_CHK_STATS_EN
   logic [CNT_W-1:0]  frame_cnt;
   logic [CNT_W-1:0]  err_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_tmo    = 0;
   int sync_seen = 0;
   int res_seen  = 0;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              e;
   } exp_t;
   exp_t exp_q[$];

   crc_ser_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ser_valid   (ser_valid),
      .ser_bit     (ser_bit),
      .ser_sof     (ser_sof),
      .ser_ready   (ser_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_crc_err (out_crc_err),
      .sync_err    (sync_err)
`ifdef CRC_CHK_STATS_EN
      ,
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Background counts of sync_err pulses and completed output handshakes.
   always @(negedge clk) begin
      if (sync_err === 1'b1) sync_seen <= sync_seen + 1;
      if (out_valid === 1'b1 && out_ready === 1'b1) res_seen <= res_seen + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      ser_valid = 1'b0;
      ser_sof   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s);
      logic rdy;
      int   waited;
      rdy = 1'b0;
      waited = 0;
      ser_valid = 1'b1;
      ser_bit   = b;
      ser_sof   = s;
      while (!rdy && waited < 200) begin
         @(negedge clk);
         rdy = (ser_ready === 1'b1);
         @(posedge clk);
         #1;
         waited++;
      end
      ser_valid = 1'b0;
      ser_sof   = 1'b0;
      if (!rdy) begin
         n_checks++;
         n_fail++;
         n_tmo++;
         $display("FAIL send_bit_timeout: ser_ready=%b, required 1", ser_ready);
      end
   endtask

   task automatic send_partial(input logic [9:0] w, input int n);
      for (int i = 9; i > 9 - n; i--) send_bit(w[i], i == 9);
   endtask

   task automatic send_word(input logic [6:0] d, input logic [2:0] c);
      send_partial({d, c}, 10);
   endtask

   task automatic do_reset();
      ser_valid = 1'b0;
      ser_sof   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 7'h00 || out_crc_err !== 1'b0 || sync_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b data=%h err=%b sync=%b, required 0/00/0/0",
                  out_valid, out_data, out_crc_err, sync_err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (ser_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ser_ready: got %b, required 1", ser_ready);
      end
`ifdef CRC_CHK_STATS_EN
      n_checks++;
      if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stats: frame=%0d err=%0d, required 0/0", frame_cnt, err_cnt);
      end
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_good();
      out_ready = 1'b1;
      send_word(7'h55, 3'b110);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h55 || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL good_word: valid=%b data=%h err=%b, required 1/55/0",
                  out_valid, out_data, out_crc_err);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL good_pop: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_corrupt();
      do_reset();
      send_word(7'h55, 3'b111);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h55 || out_crc_err !== 1'b1) begin
         n_fail++;
         $display("FAIL corrupt_55: valid=%b data=%h err=%b, required 1/55/1",
                  out_valid, out_data, out_crc_err);
      end
      send_word(7'h7F, 3'b001);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h7F || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL good_7f: valid=%b data=%h err=%b, required 1/7f/0",
                  out_valid, out_data, out_crc_err);
      end
`ifdef CRC_CHK_STATS_EN
      n_checks++;
      if (frame_cnt !== 16'd2 || err_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL stats_count: frame=%0d err=%0d, required 2/1", frame_cnt, err_cnt);
      end
`endif
   endtask

   task automatic test_backpressure();
      logic stable_ok;
      int   r0;
      idle(2);
      out_ready = 1'b0;
      send_word(7'h55, 3'b110);
      n_checks++;
      if (out_valid !== 1'b1 || ser_ready !== 1'b0 || out_data !== 7'h55) begin
         n_fail++;
         $display("FAIL bp_hold: valid=%b ser_ready=%b data=%h, required 1/0/55",
                  out_valid, ser_ready, out_data);
      end
      // First bit of 7'h00/000 waits while the result is held.
      ser_valid = 1'b1;
      ser_bit   = 1'b0;
      ser_sof   = 1'b1;
      stable_ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (ser_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 7'h55 || out_crc_err !== 1'b0)
            stable_ok = 1'b0;
      end
      n_checks++;
      if (stable_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stable: ser_ready=%b valid=%b data=%h err=%b, required 0/1/55/0",
                  ser_ready, out_valid, out_data, out_crc_err);
      end
      @(posedge clk);
      #1;
      r0 = res_seen;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ser_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 7'h55) begin
         n_fail++;
         $display("FAIL bp_first_out: ser_ready=%b valid=%b data=%h, required 1/1/55",
                  ser_ready, out_valid, out_data);
      end
      @(posedge clk);
      #1;
      ser_valid = 1'b0;
      ser_sof   = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: out_valid=%b, required 0", out_valid);
      end
      for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h00 || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_second_out: valid=%b data=%h err=%b, required 1/00/0",
                  out_valid, out_data, out_crc_err);
      end
      idle(1);
      n_checks++;
      if (res_seen - r0 !== 2) begin
         n_fail++;
         $display("FAIL bp_count: results delivered %0d, required 2", res_seen - r0);
      end
   endtask

   task automatic test_sync();
      int s0, r0;
      idle(2);
      out_ready = 1'b1;
      s0 = sync_seen;
      r0 = res_seen;
      send_partial({7'h2A, 3'b000}, 5);
      send_word(7'h7F, 3'b001);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h7F || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_result: valid=%b data=%h err=%b, required 1/7f/0",
                  out_valid, out_data, out_crc_err);
      end
      idle(1);
      n_checks++;
      if (sync_seen - s0 !== 1 || res_seen - r0 !== 1) begin
         n_fail++;
         $display("FAIL sync_counts: sync pulses %0d results %0d, required 1/1",
                  sync_seen - s0, res_seen - r0);
      end
   endtask

   task automatic test_stray_reset();
      int s0, r0;
      idle(2);
      out_ready = 1'b1;
      s0 = sync_seen;
      r0 = res_seen;
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      send_word(7'h55, 3'b110);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h55 || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_result: valid=%b data=%h err=%b, required 1/55/0",
                  out_valid, out_data, out_crc_err);
      end
      idle(1);
      n_checks++;
      if (sync_seen - s0 !== 0 || res_seen - r0 !== 1) begin
         n_fail++;
         $display("FAIL stray_counts: sync pulses %0d results %0d, required 0/1",
                  sync_seen - s0, res_seen - r0);
      end
      // A held result must vanish as soon as reset asserts.
      out_ready = 1'b0;
      send_word(7'h7F, 3'b001);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 7'h00 || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: valid=%b data=%h err=%b, required 0/00/0",
                  out_valid, out_data, out_crc_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      // Reset during bit 6 of a codeword.
      send_partial({7'h2A, 3'b000}, 5);
      ser_valid = 1'b1;
      ser_bit   = 1'b1;
      #2;
      rst_n     = 1'b0;
      ser_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      s0 = sync_seen;
      r0 = res_seen;
      send_word(7'h7F, 3'b001);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h7F || out_crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_result: valid=%b data=%h err=%b, required 1/7f/0",
                  out_valid, out_data, out_crc_err);
      end
      idle(1);
      n_checks++;
      if (sync_seen - s0 !== 0 || res_seen - r0 !== 1) begin
         n_fail++;
         $display("FAIL post_reset_counts: sync pulses %0d results %0d, required 0/1",
                  sync_seen - s0, res_seen - r0);
      end
   endtask

   task automatic test_random();
      int got;
      int cyc;
      int tmo0;
      idle(2);
      exp_q.delete();
      got  = 0;
      cyc  = 0;
      tmo0 = n_tmo;
      fork
         begin : driver
            logic [DATA_W-1:0] d;
            logic [2:0]        c;
            exp_t              e;
            for (int w = 0; w < N_RAND; w++) begin
               if (n_tmo != tmo0) break;
               d = 7'($urandom());
               c = crc_fold(64'(d));
               if ($urandom_range(0, 9) == 0) c = c ^ (3'b001 << $urandom_range(0, 2));
               e.d = d;
               e.e = (c != crc_fold(64'(d)));
               exp_q.push_back(e);
               for (int i = 9; i >= 0; i--) begin
                  if ($urandom_range(0, 4) == 0) idle(1);
                  send_bit((i >= 3) ? d[i-3] : c[i], i == 9);
               end
            end
         end
         begin : monitor
            exp_t e;
            while (got < N_RAND && cyc < 60000) begin
               @(negedge clk);
               cyc++;
               if (out_valid === 1'b1 && out_ready === 1'b1) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL rand_extra: result data=%h err=%b, required none",
                              out_data, out_crc_err);
                  end else begin
                     e = exp_q.pop_front();
                     if (out_data !== e.d || out_crc_err !== e.e) begin
                        n_fail++;
                        $display("FAIL rand_result %0d: data=%h err=%b, required %h/%b",
                                 got, out_data, out_crc_err, e.d, e.e);
                     end
                  end
                  got++;
               end
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      n_checks++;
      if (got !== N_RAND || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL rand_total: results %0d pending %0d, required %0d/0",
                  got, exp_q.size(), N_RAND);
      end
   endtask

   initial begin
      test_reset();
      test_good();
      test_corrupt();
      test_backpressure();
      test_sync();
      test_stray_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
